// File: rtl/deserializer_spi_pkg.sv
// Shared constants and state encoding for the SPI link deserializer.
// The bit-period constants match the serializer driving the link.
package deserializer_spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_BITS = 2'd2
    } state_e;

    localparam int unsigned BR_LIMIT         = 25;
    localparam int unsigned BR_LIMIT_HALF    = 12;
    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_HIGH_TIMEOUT = 40;
    localparam int unsigned DEF_LOW_TIMEOUT  = 40;
    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned BIT_CNT_W        = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/synchronizer_2ff.sv
// Multi-flop synchronizer for a single asynchronous bit with a configurable reset value.
module synchronizer_2ff #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/deserializer_spi.sv
// Receiver for the SPI-style serial link: syncs Rx_Clk/Rx_Data, frames bytes LSb first,
// and hands them downstream over valid/ready with sticky overrun and framing flags.
module deserializer_spi
    import deserializer_spi_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned HIGH_TIMEOUT = DEF_HIGH_TIMEOUT,
    parameter int unsigned LOW_TIMEOUT  = DEF_LOW_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Rx_Clk,
    input  logic              Rx_Data,
    output logic [BYTE_W-1:0] source_Data,
    output logic              source_DataValid,
    input  logic              source_ready,
    output logic              rx_busy,
    output logic              rx_over_run,
    output logic              rx_framing_error,
    input  logic              clear_errors
);

    localparam int unsigned TMAX    = max_u(HIGH_TIMEOUT, LOW_TIMEOUT);
    localparam int unsigned TIMER_W = $clog2(TMAX + 1);

    // Elaboration-time sanity checks on the link configuration.
    if (SYNC_STAGES < 2)              begin : g_bad_sync  $error("SYNC_STAGES must be >= 2");              end
    if (HIGH_TIMEOUT <= BR_LIMIT)     begin : g_bad_high  $error("HIGH_TIMEOUT must exceed the bit period"); end
    if (LOW_TIMEOUT <= BR_LIMIT_HALF) begin : g_bad_low   $error("LOW_TIMEOUT must exceed the low phase");  end
    if (CLK_HZ == 0)                  begin : g_bad_clk   $error("CLK_HZ must be non-zero");                end

    logic rx_clk_s;
    logic rx_data_s;
    logic rx_clk_prev_q;
    logic rise_c;
    logic fall_c;

    synchronizer_2ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (Rx_Clk),
        .q_o   (rx_clk_s)
    );

    synchronizer_2ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_data (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (Rx_Data),
        .q_o   (rx_data_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_clk_prev_q <= 1'b1;
        else          rx_clk_prev_q <= rx_clk_s;
    end

    assign rise_c = ~rx_clk_prev_q &  rx_clk_s;
    assign fall_c =  rx_clk_prev_q & ~rx_clk_s;

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TIMER_W-1:0]     timer_q, timer_d, timer_inc_c;
    logic [BYTE_W-1:0]      shift_q, shift_d;
    logic [BYTE_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   busy_q;
    logic                   over_q, over_d;
    logic                   ferr_q, ferr_d;
    logic                   byte_done_c;
    logic                   ferr_set_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            over_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= (state_d != S_IDLE);
            over_q    <= over_d;
            ferr_q    <= ferr_d;
        end
    end

    // Frame FSM, byte assembly, handshake and sticky status.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        timer_d     = timer_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q & ~source_ready;
        byte_done_c = 1'b0;
        ferr_set_c  = 1'b0;
        timer_inc_c = (timer_q == TIMER_W'(TMAX)) ? timer_q : TIMER_W'(timer_q + 1'b1);

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (fall_c) begin
                    state_d = S_SYNC;
                    timer_d = '0;
                end
            end
            S_SYNC: begin
                if (rise_c) begin
                    state_d   = S_BITS;
                    bit_cnt_d = '0;
                    timer_d   = '0;
                end else if (timer_q >= TIMER_W'(LOW_TIMEOUT)) begin
                    ferr_set_c = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    timer_d = timer_inc_c;
                end
            end
            S_BITS: begin
                // A full byte is published the cycle after its 8th bit is shifted in.
                if (bit_cnt_q == BIT_CNT_W'(BYTE_W)) begin
                    byte_done_c = 1'b1;
                    bit_cnt_d   = '0;
                end
                if (fall_c) begin
                    shift_d   = {rx_data_s, shift_q[BYTE_W-1:1]};
                    bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
                    timer_d   = '0;
                end else if (rise_c) begin
                    timer_d = '0;
                end else if (rx_clk_s && (timer_q >= TIMER_W'(HIGH_TIMEOUT))) begin
                    ferr_set_c = (bit_cnt_q != '0);
                    state_d    = S_IDLE;
                    bit_cnt_d  = '0;
                end else if (!rx_clk_s && (timer_q >= TIMER_W'(LOW_TIMEOUT))) begin
                    ferr_set_c = 1'b1;
                    state_d    = S_IDLE;
                    bit_cnt_d  = '0;
                end else begin
                    timer_d = timer_inc_c;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        if (byte_done_c) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end

        over_d = (over_q & ~clear_errors) | (byte_done_c & valid_q & ~source_ready);
        ferr_d = (ferr_q & ~clear_errors) | ferr_set_c;
    end

    assign source_Data      = data_q;
    assign source_DataValid = valid_q;
    assign rx_busy          = busy_q;
    assign rx_over_run      = over_q;
    assign rx_framing_error = ferr_q;

endmodule

// File: tb/tb_deserializer_spi.sv
// Self-checking bench for deserializer_spi: drives serializer-like frames and scoreboards bytes.
module tb_deserializer_spi;

    localparam int unsigned T_HIGH  = 12;
    localparam int unsigned T_LOW   = 13;
    localparam int unsigned T_SYNC  = 12;
    localparam int unsigned LATENCY = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       Rx_Clk;
    logic       Rx_Data;
    logic [7:0] source_Data;
    logic       source_DataValid;
    logic       source_ready;
    logic       rx_busy;
    logic       rx_over_run;
    logic       rx_framing_error;
    logic       clear_errors;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_rx     = 0;
    logic [7:0] exp_q[$];

    deserializer_spi dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .Rx_Clk           (Rx_Clk),
        .Rx_Data          (Rx_Data),
        .source_Data      (source_Data),
        .source_DataValid (source_DataValid),
        .source_ready     (source_ready),
        .rx_busy          (rx_busy),
        .rx_over_run      (rx_over_run),
        .rx_framing_error (rx_framing_error),
        .clear_errors     (clear_errors)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sync_phase();
        Rx_Clk = 1'b0;
        cyc(T_SYNC);
    endtask

    task automatic send_bit(input logic v, input int low_cyc);
        Rx_Data = v;
        Rx_Clk  = 1'b1;
        cyc(T_HIGH);
        Rx_Clk  = 1'b0;
        cyc(low_cyc);
    endtask

    task automatic send_bits(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) send_bit(d[i], T_LOW);
    endtask

    task automatic end_frame(input int n);
        Rx_Clk = 1'b1;
        cyc(n);
    endtask

    // Scoreboard: every accepted byte is matched against the oldest expected one.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (reset_n && source_DataValid && source_ready) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~source_Data;
            n_rx++;
            check("rx_byte", 32'(source_Data), 32'(exp));
        end
    end

    initial begin
        reset_n      = 1'b0;
        Rx_Clk       = 1'b1;
        Rx_Data      = 1'b1;
        source_ready = 1'b0;
        clear_errors = 1'b0;
        #2;
        check("rst_valid", 32'(source_DataValid), 32'd0);
        check("rst_data",  32'(source_Data),      32'd0);
        cyc(3);
        reset_n = 1'b1;
        cyc(3);
        check("idle_busy", 32'(rx_busy),          32'd0);
        check("idle_over", 32'(rx_over_run),      32'd0);
        check("idle_ferr", 32'(rx_framing_error), 32'd0);

        // Single byte 0xA5 with exact valid latency after the 8th fall.
        source_ready = 1'b1;
        exp_q.push_back(8'hA5);
        sync_phase();
        check("sync_busy", 32'(rx_busy), 32'd1);
        send_bits(32'hA5, 7);
        send_bit(1'b1, 0);
        cyc(LATENCY - 1);
        check("lat_early", 32'(source_DataValid), 32'd0);
        cyc(1);
        check("lat_valid", 32'(source_DataValid), 32'd1);
        check("lat_data",  32'(source_Data),      32'hA5);
        cyc(T_LOW - LATENCY);
        end_frame(50);
        check("a5_busy", 32'(rx_busy),          32'd0);
        check("a5_over", 32'(rx_over_run),      32'd0);
        check("a5_ferr", 32'(rx_framing_error), 32'd0);

        // Back-to-back bytes under one sync phase.
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hFF);
        sync_phase();
        send_bits(32'h00FF8001, 12);
        check("b2b_busy_mid", 32'(rx_busy), 32'd1);
        send_bits(32'h00000FF8, 12);
        Rx_Clk = 1'b1;
        cyc(30);
        check("b2b_busy_tail", 32'(rx_busy), 32'd1);
        cyc(20);
        check("b2b_busy_end", 32'(rx_busy),          32'd0);
        check("b2b_ferr",     32'(rx_framing_error), 32'd0);

        // Overrun: second byte overwrites an unconsumed first byte.
        source_ready = 1'b0;
        exp_q.push_back(8'hC3);
        sync_phase();
        send_bits(32'h0000C33C, 16);
        end_frame(50);
        check("ovr_data",  32'(source_Data),      32'hC3);
        check("ovr_valid", 32'(source_DataValid), 32'd1);
        check("ovr_flag",  32'(rx_over_run),      32'd1);
        check("ovr_ferr",  32'(rx_framing_error), 32'd0);
        clear_errors = 1'b1;
        cyc(1);
        clear_errors = 1'b0;
        cyc(1);
        check("ovr_clr",       32'(rx_over_run),      32'd0);
        check("ovr_valid_hold", 32'(source_DataValid), 32'd1);
        source_ready = 1'b1;
        cyc(3);
        check("ovr_drained", 32'(source_DataValid), 32'd0);

        // Truncated frame ends on high timeout, then a clean 0x5A frame.
        sync_phase();
        send_bits(32'h1F, 5);
        end_frame(50);
        check("trunc_ferr",  32'(rx_framing_error), 32'd1);
        check("trunc_valid", 32'(source_DataValid), 32'd0);
        check("trunc_busy",  32'(rx_busy),          32'd0);
        clear_errors = 1'b1;
        cyc(1);
        clear_errors = 1'b0;
        exp_q.push_back(8'h5A);
        sync_phase();
        send_bits(32'h5A, 8);
        end_frame(50);
        check("5a_ferr", 32'(rx_framing_error), 32'd0);
        check("5a_data", 32'(source_Data),      32'h5A);

        // Sync phase stuck low.
        Rx_Clk = 1'b0;
        cyc(30);
        check("stuck_early_ferr", 32'(rx_framing_error), 32'd0);
        check("stuck_early_busy", 32'(rx_busy),          32'd1);
        cyc(30);
        check("stuck_ferr", 32'(rx_framing_error), 32'd1);
        check("stuck_busy", 32'(rx_busy),          32'd0);
        end_frame(10);
        clear_errors = 1'b1;
        cyc(1);
        clear_errors = 1'b0;
        cyc(1);
        check("stuck_clr", 32'(rx_framing_error), 32'd0);

        // Asynchronous reset in the middle of a byte, then a full 0x99 frame.
        sync_phase();
        send_bits(32'h99, 3);
        Rx_Clk = 1'b1;
        cyc(5);
        check("mid_busy", 32'(rx_busy), 32'd1);
        reset_n = 1'b0;
        #2;
        check("arst_data",  32'(source_Data),      32'd0);
        check("arst_valid", 32'(source_DataValid), 32'd0);
        check("arst_busy",  32'(rx_busy),          32'd0);
        check("arst_ferr",  32'(rx_framing_error), 32'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(50);
        exp_q.push_back(8'h99);
        sync_phase();
        send_bits(32'h99, 8);
        end_frame(50);
        check("99_data", 32'(source_Data),      32'h99);
        check("99_ferr", 32'(rx_framing_error), 32'd0);

        check("rx_count", 32'(n_rx),         32'd7);
        check("sb_left",  32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/deserializer_spi.md
Name: deserializer_SPI

Overview:
- Receiver end of the 4 Mbps synchronous serial link driven by the team's SPI serializer.
- Samples Rx_Data/Rx_Clk from the link (Rx_Clk idles high), detects the frame-sync low phase, and shifts in bytes LSb first.
- Presents each byte through a valid/ready handshake to downstream logic in the 100 MHz system domain.
- Flags overrun and framing errors as sticky status bits.

Parameters:
- CLK_HZ, 100000000, system clock frequency (documentation only; not used in logic).
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer, minimum 2.
- HIGH_TIMEOUT, 40, system cycles Rx_Clk must stay high after a bit before the frame is declared ended (must exceed the 25-cycle bit period).
- LOW_TIMEOUT, 40, system cycles Rx_Clk may stay low before the frame is aborted as stuck.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- Rx_Clk  in  1  link clock; asynchronous to clk; idles high.
- Rx_Data  in  1  link data; changes on Rx_Clk rising edge, stable across the falling edge.
- source_Data  out  8  received byte.
- source_DataValid  out  1  source_Data holds an unconsumed byte.
- source_ready  in  1  downstream accepts the byte when source_ready and source_DataValid are both high.
- rx_busy  out  1  frame in progress (state is not IDLE).
- rx_over_run  out  1  sticky; a completed byte overwrote an unconsumed one.
- rx_framing_error  out  1  sticky; frame ended or aborted mid-byte, or sync phase stuck low.
- clear_errors  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0; synchronizer flops preset to 1 so no false edge is seen at release; state IDLE; bit_cnt 0; timer 0.
- Synchronizer: Rx_Clk and Rx_Data pass through identical SYNC_STAGES chains, so they stay aligned. An extra register on Rx_Clk gives rise and fall detection. A pin edge is seen SYNC_STAGES+1 cycles later.
- IDLE: on a synchronized Rx_Clk fall, go to SYNC and clear the timer.
- SYNC: on a rise, go to BITS with bit_cnt 0. If the low time reaches LOW_TIMEOUT, set rx_framing_error and go to IDLE.
- BITS, on each fall: shift_reg <= {Rx_Data_sync, shift_reg[7:1]} (LSb first) and bit_cnt++.
  - When bit_cnt reaches 8: load source_Data, raise source_DataValid, reset bit_cnt to 0, stay in BITS.
  - Back-to-back bytes arrive with no new sync phase.
- BITS, timer: counts cycles since the last edge.
  - Rx_Clk high for HIGH_TIMEOUT cycles: if bit_cnt==0, normal end of frame; otherwise set rx_framing_error. Either way, go to IDLE, clear bit_cnt, discard the partial byte.
  - Rx_Clk low for LOW_TIMEOUT cycles: set rx_framing_error and go to IDLE.
- Byte latency: source_DataValid rises SYNC_STAGES+2 cycles after the 8th pin falling edge.
- Handshake:
  - source_DataValid stays high until a cycle with source_ready high, then drops the next cycle.
  - If a byte completes in the same cycle that the previous byte is accepted: no overrun, new data is loaded, valid stays 1.
  - If a byte completes while valid is high and the byte is not accepted: overwrite source_Data, keep valid 1, set rx_over_run.
- Sticky flags: cleared only by clear_errors or reset. If clear_errors coincides with a new error event, the set wins.
- Timer: saturates at max(HIGH_TIMEOUT, LOW_TIMEOUT); it must not wrap.
- Illegal state encoding: return to IDLE, clear bit_cnt.
- Reset mid-frame: everything clears immediately. The next frame is received only after its sync fall; the remaining bits of the interrupted frame are ignored via timeout.

Decomposition:
- Shared package: state localparams (S_IDLE=0, S_SYNC=1, S_BITS=2), the bit-period constants shared with the serializer (BR_LIMIT=25, BR_Limit_Half=12), and the default timeouts.
- Sub-module synchronizer_2ff: parameterised depth and reset value, one instance each for Rx_Clk and Rx_Data.

Test Plan:
- Serializer-accurate waveform (12-cycle sync low, 25-cycle bits), byte 0xA5, source_ready=1 -> one valid pulse with source_Data=0xA5, 4 cycles after the 8th fall; no flags set.
- Back-to-back 0x01, 0x80, 0xFF with a single sync -> three valids in order; rx_busy high throughout, low HIGH_TIMEOUT cycles after the last bit.
- source_ready=0 while 0x3C then 0xC3 arrive -> source_Data=0xC3, rx_over_run=1; pulse clear_errors -> flag 0, valid still 1 until ready.
- Frame of 5 bits then Rx_Clk held high 50 cycles -> rx_framing_error=1, no valid, state IDLE; a following 0x5A frame is received correctly.
- Rx_Clk held low 60 cycles after a sync fall -> rx_framing_error=1 at 40 cycles, state IDLE.
- reset_n pulsed low mid-byte -> all outputs 0 asynchronously; the next full frame of 0x99 yields source_Data=0x99.
